// File: rtl/serv_ibus_resp.sv
// serv_ibus_resp: Wishbone ibus responder with programmable wait states; SERV_IBUS_PREFETCH_EN adds a one-word next-line prefetch buffer.
module serv_ibus_resp #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [31:0]              i_ibus_adr,
  input  logic                     i_ibus_cyc,
  output logic [31:0]              o_ibus_rdt,
  output logic                     o_ibus_ack,
  input  logic                     i_ld_we,
  input  logic [$clog2(DEPTH)-1:0] i_ld_adr,
  input  logic [31:0]              i_ld_dat,
  output logic                     o_oob
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d, rdt_q, rdt_d, mem_rd, buf_rd;
  logic oob_q, oob_d, in_range, hit, use_buf, unused_ok;
  logic [31:0] mem [DEPTH];
  assign in_range = adr_q[31:AW+2] == '0;
  assign mem_rd = mem[adr_q[AW+1:2]];
  assign unused_ok = ^adr_q[1:0];
  assign o_ibus_ack = state_q == ACK;
  assign o_ibus_rdt = rdt_q;
  assign o_oob = oob_q;
  always_ff @(posedge i_clk) begin
    if (i_ld_we) mem[i_ld_adr] <= i_ld_dat;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      adr_q <= '0;
      rdt_q <= '0;
      oob_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      adr_q <= adr_d;
      rdt_q <= rdt_d;
      oob_q <= oob_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    adr_d = adr_q;
    rdt_d = rdt_q;
    oob_d = oob_q;
    unique case (state_q)
      IDLE: if (i_ibus_cyc) begin
        state_d = WAIT;
        adr_d = i_ibus_adr;
        cnt_d = hit ? 4'd0 : LAT;
      end
      WAIT: if (!i_ibus_cyc) state_d = IDLE;
      else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        state_d = ACK;
        rdt_d = !in_range ? 32'd0 : use_buf ? buf_rd : mem_rd;
        oob_d = oob_q | !in_range;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef SERV_IBUS_PREFETCH_EN
  logic pf_val_q, pf_busy_q, hit_q;
  logic [AW-1:0] pf_adr_q;
  logic [31:0] pf_dat_q;
  logic [3:0] pf_cnt_q;
  assign hit = pf_val_q && i_ibus_adr[31:AW+2] == '0 && i_ibus_adr[AW+1:2] == pf_adr_q;
  assign use_buf = hit_q;
  assign buf_rd = pf_dat_q;
  // A new request always wins over the background read, so an in-flight prefetch is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pf_val_q <= 1'b0;
      pf_busy_q <= 1'b0;
      pf_cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      if (state_q == IDLE && i_ibus_cyc) begin
        hit_q <= hit;
        pf_busy_q <= 1'b0;
      end else if (state_q == ACK && in_range && adr_q[AW+1:2] != '1) begin
        pf_busy_q <= 1'b1;
        pf_val_q <= 1'b0;
        pf_cnt_q <= LAT;
        pf_adr_q <= adr_q[AW+1:2] + 1'b1;
      end else if (pf_busy_q) begin
        if (pf_cnt_q != 4'd0) pf_cnt_q <= pf_cnt_q - 4'd1;
        else begin
          pf_busy_q <= 1'b0;
          pf_val_q <= 1'b1;
          pf_dat_q <= mem[pf_adr_q];
        end
      end
      if (i_ld_we) begin
        pf_val_q <= 1'b0;
        pf_busy_q <= 1'b0;
      end
    end
  end
`else
  assign hit = 1'b0;
  assign use_buf = 1'b0;
  assign buf_rd = '0;
`endif
endmodule

// File: tb/tb_serv_ibus_resp.sv
// tb_serv_ibus_resp: randomized fetch/load/abort/reset traffic against a transaction-level model of serv_ibus_resp.
module tb_serv_ibus_resp;
  localparam int L = 4;
  localparam int D = 16;
  logic clk = 1'b0, rst = 1'b1, cyc = 1'b0, ld_we = 1'b0, ack, oob;
  logic [31:0] adr = '0, ld_dat = '0, rdt;
  logic [3:0] ld_adr = '0;
  int n_chk = 0, n_err = 0, cyc_n = 0;
  logic [31:0] m_mem [D];
  logic m_oob = 1'b0;
  int m_pf_word = -1, m_pf_start = -1000, m_last_we = -1000;
  logic [31:0] prev_a = '0;

  serv_ibus_resp #(.DEPTH(D), .LATENCY(L)) dut (
    .i_clk(clk), .i_rst(rst), .i_ibus_adr(adr), .i_ibus_cyc(cyc),
    .o_ibus_rdt(rdt), .o_ibus_ack(ack), .i_ld_we(ld_we), .i_ld_adr(ld_adr),
    .i_ld_dat(ld_dat), .o_oob(oob)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, act, exp, cyc_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Buffer is usable once LATENCY+1 cycles have elapsed after the ack cycle with no load since.
  task automatic model_req(input int e, input logic [31:0] a, output bit hit);
    hit = 1'b0;
`ifdef SERV_IBUS_PREFETCH_EN
    if (m_pf_word >= 0 && e >= m_pf_start + L + 3 && m_last_we <= m_pf_start)
      hit = a[31:6] == 0 && int'(a[5:2]) == m_pf_word;
    else m_pf_word = -1;
`endif
  endtask

  task automatic load(input int w, input logic [31:0] d);
    ld_we = 1'b1; ld_adr = 4'(w); ld_dat = d;
    tick();
    ld_we = 1'b0;
    m_mem[w] = d;
    m_last_we = cyc_n;
  endtask

  task automatic fetch(input logic [31:0] a);
    bit hit, inr;
    int lat, w;
    cyc = 1'b1; adr = a;
    tick();
    model_req(cyc_n, a, hit);
    inr = a[31:6] == 0;
    w = int'(a[5:2]);
    lat = 0;
    while (!ack && lat < 40) begin
      tick();
      lat++;
    end
    check("fetch_lat", 32'(lat), 32'(hit ? 1 : L + 1));
    check("fetch_rdt", rdt, inr ? m_mem[w] : 32'd0);
    if (!inr) m_oob = 1'b1;
    check("oob", 32'(oob), 32'(m_oob));
    cyc = 1'b0;
    if (inr && w != D - 1) begin
      m_pf_word = w + 1;
      m_pf_start = cyc_n;
    end
    tick();
    check("ack_single", 32'(ack), 32'd0);
    prev_a = a;
  endtask

  task automatic abort(input logic [31:0] a);
    bit hit, seen;
    cyc = 1'b1; adr = a;
    tick();
    model_req(cyc_n, a, hit);
    repeat (hit ? 0 : $urandom_range(0, L)) tick();
    cyc = 1'b0;
    seen = 1'b0;
    repeat (L + 4) begin
      tick();
      seen |= ack;
    end
    check("abort_ack", 32'(seen), 32'd0);
  endtask

  task automatic rst_mid(input logic [31:0] a);
    bit hit;
    cyc = 1'b1; adr = a;
    tick();
    model_req(cyc_n, a, hit);
    rst = 1'b1; cyc = 1'b0;
    tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdt", rdt, 32'd0);
    check("rst_oob", 32'(oob), 32'd0);
    rst = 1'b0;
    m_oob = 1'b0;
    m_pf_word = -1;
    tick();
    check("rst_ack2", 32'(ack), 32'd0);
  endtask

  task automatic rbw();
    load(3, 32'h11111111);
    cyc = 1'b1; adr = 32'hC;
    tick();
    repeat (L) tick();
    ld_we = 1'b1; ld_adr = 4'd3; ld_dat = 32'hDEADBEEF;
    tick();
    check("rbw_ack", 32'(ack), 32'd1);
    check("rbw_rdt", rdt, 32'h11111111);
    ld_we = 1'b0; cyc = 1'b0;
    m_mem[3] = 32'hDEADBEEF;
    m_last_we = cyc_n;
    m_pf_word = 4;
    m_pf_start = cyc_n;
    tick();
    check("rbw_ack_single", 32'(ack), 32'd0);
    fetch(32'hC);
  endtask

  task automatic b2b(input int w);
    int prev, acks, n;
    n = 5 * (L + 3);
    load(w, $urandom);
    cyc = 1'b1; adr = 32'(w) << 2;
    prev = -1; acks = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ack) begin
        if (prev >= 0) check("b2b_gap", 32'(cyc_n - prev), 32'(L + 3));
        check("b2b_rdt", rdt, m_mem[w]);
        prev = cyc_n;
        acks++;
      end
    end
    cyc = 1'b0;
    check("b2b_count", 32'(acks), 32'((n - (L + 2)) / (L + 3) + 1));
    load(w, $urandom);
  endtask

  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 99);
    if (r < 50) return prev_a[31:6] == 0 ? prev_a + 32'd4 : 32'd0;
    if (r < 85) return {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    return $urandom;
  endfunction

  initial begin
    repeat (2) tick();
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_rdt", rdt, 32'd0);
    check("reset_oob", 32'(oob), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < D; i++) load(i, $urandom);
    load(5, 32'h00500093);
    load(0, 32'h00000013);
    fetch(32'h14);
    fetch(32'h0);
    repeat (6) tick();
    fetch(32'h4);
    fetch(32'h0);
    load(7, 32'h00700113);
    repeat (6) tick();
    fetch(32'h4);
    fetch(32'h3C);
    repeat (8) tick();
    fetch(32'h0);
    fetch(32'h400);
    fetch(32'h14);
    repeat (8) tick();
    fetch(32'h18);
    abort(32'h8);
    rst_mid(32'h10);
    fetch(32'h10);
    rbw();
    b2b(2);
    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) fetch(pick());
      else if (r < 82) load($urandom_range(0, D - 1), $urandom);
      else if (r < 92) abort(pick());
      else if (r < 95) rst_mid(pick());
      repeat ($urandom_range(0, 8)) tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/serv_ibus_resp.md
# serv_ibus_resp

Wishbone-classic instruction-bus responder that serves 32-bit instruction words to the core's fetch interface, which is the other end of the path whose data the instruction decoder latches. It holds a word-addressed instruction memory, loaded through a separate load port. Each fetch is answered after a programmable number of wait states with a one-cycle acknowledge. It sits between the core's ibus master and an on-chip program store in simulation and FPGA test systems.

## Interface
Parameters:
- DEPTH, 256: memory size in 32-bit words; power of two, 4..65536; AW = log2(DEPTH).
- LATENCY, 1: wait states before acknowledge, 0..15.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_ibus_adr  in  32  byte address of the fetch; bits [1:0] ignored.
- i_ibus_cyc  in  1  fetch request, held by the master until ack.
- o_ibus_rdt  out  32  instruction word; valid while o_ibus_ack=1.
- o_ibus_ack  out  1  one-cycle acknowledge.
- i_ld_we  in  1  load-port write strobe.
- i_ld_adr  in  AW  load-port word address.
- i_ld_dat  in  32  load-port write data.
- o_oob  out  1  sticky flag: a fetch addressed beyond DEPTH words.

## Operation
- States: IDLE, WAIT, ACK. Wait counter is 4 bits wide.
- IDLE: when i_ibus_cyc=1, capture i_ibus_adr and load the counter with LATENCY, then go to WAIT.
- WAIT: decrement the counter while it is nonzero. When it is 0, read the memory into o_ibus_rdt and go to ACK.
- WAIT with i_ibus_cyc=0: abort to IDLE, with no ack and o_ibus_rdt unchanged.
- ACK: assert o_ibus_ack for exactly one cycle, then go to IDLE. If i_ibus_cyc is still high in IDLE, it is a new request.
- Range check: the fetch is in range when captured adr[31:AW+2] == 0. The memory index is adr[AW+1:2].
- Out-of-range fetch: o_ibus_rdt=0x00000000, still acked with the normal timing, and o_oob is set to 1. o_oob stays 1 until reset.
- Load port: a write occurs on any edge with i_ld_we=1, regardless of FSM state.
- Read and write on the same edge to the same word: the read returns the old content (read-before-write).
- Memory content is not cleared by reset.

## Timing
- Reset values: o_ibus_ack=0, o_ibus_rdt=0, o_oob=0, state IDLE, counter 0.
- Latency: i_ibus_cyc first sampled high at edge N. o_ibus_ack is high in the cycle after edge N+LATENCY+1.
- Example, LATENCY=0: cyc sampled at edge 0, ack visible after edge 1.
- o_ibus_rdt holds its value between acks.
- Reset mid-operation: the edge with i_rst=1 returns the FSM to IDLE and forces ack low. Memory is unaffected.
- Back-to-back: minimum spacing between acks is LATENCY+3 cycles. Ack is never asserted in two consecutive cycles.

## Configuration
- Macro SERV_IBUS_PREFETCH_EN.
- Defined: after each in-range ack at word W, the block reads word W+1 into a one-entry buffer (buffer address plus valid bit). The read takes LATENCY+1 cycles in a background counter.
  - Buffer hit: a new request whose address equals the buffered address with valid=1 is acked one cycle after cyc is sampled, using the buffered data.
  - Buffer miss: a request that misses, or that arrives while the prefetch is still in flight, cancels the prefetch and takes the normal path.
  - Invalidation: any i_ld_we write invalidates the buffer.
  - Wrap: no prefetch when W+1 == DEPTH.
- Undefined: no buffer exists, and every fetch takes the full LATENCY+1 path.

## Test plan
- Load word 5 with 0x00500093, LATENCY=1. Fetch adr 0x14 -> ack exactly 2 cycles after cyc is sampled, rdt=0x00500093, single-cycle ack.
- LATENCY=0, fetch adr 0x0 after loading 0x00000013 -> ack on the next cycle with rdt=0x00000013. Five back-to-back fetches -> ack is never high in adjacent cycles.
- DEPTH=256, fetch adr 0x400 -> rdt=0x00000000 and ack asserted. o_oob=1 and stays 1 through later in-range fetches, until i_rst.
- Drop cyc during WAIT (LATENCY=5) -> no ack. Assert i_rst during WAIT on a second fetch -> ack stays 0 and a fresh fetch completes normally.
- Load write to word 3 (0xDEADBEEF) on the same edge as the read of word 3 (old content 0x11111111) -> rdt=0x11111111. The next fetch of word 3 returns 0xDEADBEEF.
- With SERV_IBUS_PREFETCH_EN, LATENCY=4:
  - Fetch 0x0, wait 6 cycles, fetch 0x4 -> ack in 1 cycle.
  - Repeat with a load write in between -> ack in 5 cycles.
  - Fetch the last word (index 255) -> no prefetch occurs.
